// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package multdiv_pkg;

   localparam int unsigned COUNT_W         = 6;
   localparam int unsigned MULT_CYCLES_DEF = 16;
   localparam int unsigned DIV_CYCLES_DEF  = 32;

   localparam logic [COUNT_W-1:0] MAX_COUNT = 6'd33;

   typedef enum logic [1:0] {
      StIdle,
      StRunMult,
      StRunDiv,
      StDone
   } state_e;

endpackage

// File: rtl/multdiv_cycle_counter.sv
// Iteration counter with synchronous clear/enable and a terminal-count compare.
module multdiv_cycle_counter
   import multdiv_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic [COUNT_W-1:0] terminal,
   output logic [COUNT_W-1:0] count,
   output logic               match
);

   // Holds at MAX_COUNT rather than wrapping.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != MAX_COUNT)) begin
         count <= count + 1'b1;
      end
   end

   assign match = (count == terminal);

endmodule

// File: rtl/multdiv_controller.sv
// Sequencer for the shared iterative multiply/divide datapath.
// Optional performance counters are built when MULTDIV_PERF_EN is defined.
module multdiv_controller
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ctrl_MULT,
   input  logic               ctrl_DIV,
   input  logic [WIDTH-1:0]   data_operandA,
   input  logic [WIDTH-1:0]   data_operandB,
   input  logic [WIDTH-1:0]   mult_result,
   input  logic               mult_ovf,
   input  logic [WIDTH-1:0]   div_result,
   output logic [WIDTH-1:0]   op_a,
   output logic [WIDTH-1:0]   op_b,
   output logic [COUNT_W-1:0] count,
   output logic               mult_active,
   output logic               div_active,
   output logic               busy,
   output logic [WIDTH-1:0]   data_result,
   output logic               data_exception,
   output logic               data_resultRDY
`ifdef MULTDIV_PERF_EN
   ,
   output logic [15:0]        perf_ops,
   output logic [15:0]        perf_exc
`endif
);

   localparam logic [COUNT_W-1:0] MULT_TERM = COUNT_W'(MULT_CYCLES);
   localparam logic [COUNT_W-1:0] DIV_TERM  = COUNT_W'(DIV_CYCLES);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   op_a_d, op_b_d, result_d;
   logic               exc_d;
   logic               accept, running, cnt_clear, cnt_match;
   logic [COUNT_W-1:0] terminal;

   assign accept   = ctrl_MULT | ctrl_DIV;
   assign running  = (state_q == StRunMult) | (state_q == StRunDiv);
   assign terminal = (state_q == StRunDiv) ? DIV_TERM : MULT_TERM;

   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a;
      op_b_d   = op_b;
      result_d = data_result;
      exc_d    = data_exception;
      if (accept) begin
         // A new request always wins: it aborts whatever is in flight.
         op_a_d = data_operandA;
         op_b_d = data_operandB;
         exc_d  = 1'b0;
         if (ctrl_MULT) begin
            state_d = StRunMult;
         end else if (data_operandB == '0) begin
            state_d  = StDone;
            result_d = '0;
            exc_d    = 1'b1;
         end else begin
            state_d = StRunDiv;
         end
      end else begin
         case (state_q)
            StRunMult: begin
               if (cnt_match) begin
                  state_d  = StDone;
                  result_d = mult_result;
                  exc_d    = mult_ovf;
               end
            end
            StRunDiv: begin
               if (cnt_match) begin
                  state_d  = StDone;
                  result_d = div_result;
                  exc_d    = 1'b0;
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   assign cnt_clear = accept | ~running | (state_d == StDone);

   multdiv_cycle_counter u_counter (
      .clock    (clock),
      .reset    (reset),
      .clear    (cnt_clear),
      .enable   (running),
      .terminal (terminal),
      .count    (count),
      .match    (cnt_match)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= StIdle;
         op_a           <= '0;
         op_b           <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_a           <= op_a_d;
         op_b           <= op_b_d;
         data_result    <= result_d;
         data_exception <= exc_d;
      end
   end

   assign mult_active    = (state_q == StRunMult);
   assign div_active     = (state_q == StRunDiv);
   assign busy           = (state_q != StIdle);
   assign data_resultRDY = (state_q == StDone);

`ifdef MULTDIV_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_ops <= '0;
         perf_exc <= '0;
      end else if (state_q == StDone) begin
         if (perf_ops != 16'hFFFF) perf_ops <= perf_ops + 1'b1;
         if (data_exception && (perf_exc != 16'hFFFF)) perf_exc <= perf_exc + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_multdiv_controller.sv
// Self-checking bench for multdiv_controller: directed table, corner sequences, random vs model.
module tb_multdiv_controller;

   localparam int MULT_N = 16;
   localparam int DIV_N  = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0, data_operandB = '0;
   logic [31:0] mult_result = '0, div_result = '0;
   logic        mult_ovf = 1'b0;
   logic [31:0] op_a, op_b, data_result;
   logic [5:0]  count;
   logic        mult_active, div_active, busy, data_exception, data_resultRDY;
`ifdef MULTDIV_PERF_EN
   logic [15:0] perf_ops, perf_exc;
`endif

   int checks = 0;
   int errors = 0;

   multdiv_controller dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .mult_result    (mult_result),
      .mult_ovf       (mult_ovf),
      .div_result     (div_result),
      .op_a           (op_a),
      .op_b           (op_b),
      .count          (count),
      .mult_active    (mult_active),
      .div_active     (div_active),
      .busy           (busy),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
`ifdef MULTDIV_PERF_EN
      ,
      .perf_ops       (perf_ops),
      .perf_exc       (perf_exc)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          is_mult;
      bit          is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] dp;
      bit          ovf;
      logic [31:0] exp_res;
      bit          exp_exc;
      int          exp_lat;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " op_a"}, op_a, 32'd0);
      check({tag, " op_b"}, op_b, 32'd0);
      check({tag, " count"}, 32'(count), 32'd0);
      check({tag, " mult_active"}, 32'(mult_active), 32'd0);
      check({tag, " div_active"}, 32'(div_active), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " result"}, data_result, 32'd0);
      check({tag, " exception"}, 32'(data_exception), 32'd0);
      check({tag, " rdy"}, 32'(data_resultRDY), 32'd0);
   endtask

   task automatic drive_req(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
   endtask

   // Issue a table request and measure latency, busy length and peak count up to resultRDY.
   task automatic run_vec(input int idx);
      int lat = 0, busy_n = 0, max_cnt = 0;
      @(negedge clock);
      mult_result = tbl[idx].dp;
      div_result  = tbl[idx].dp;
      mult_ovf    = tbl[idx].ovf;
      drive_req(tbl[idx].is_mult, tbl[idx].is_div, tbl[idx].a, tbl[idx].b);
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if (i == 1) drive_req(1'b0, 1'b0, 32'd0, 32'd0);
         if (busy) busy_n++;
         if (int'(count) > max_cnt) max_cnt = int'(count);
         if (data_resultRDY) begin
            lat = i;
            break;
         end
      end
      check($sformatf("vec%0d latency", idx), 32'(lat), 32'(tbl[idx].exp_lat));
      check($sformatf("vec%0d busy_cycles", idx), 32'(busy_n), 32'(tbl[idx].exp_lat));
      check($sformatf("vec%0d max_count", idx), 32'(max_cnt),
            32'((tbl[idx].exp_lat > 2) ? tbl[idx].exp_lat - 2 : 0));
      check($sformatf("vec%0d result", idx), data_result, tbl[idx].exp_res);
      check($sformatf("vec%0d exception", idx), 32'(data_exception), 32'(tbl[idx].exp_exc));
      @(negedge clock);
      check($sformatf("vec%0d rdy_drop", idx), 32'(data_resultRDY), 32'd0);
      check($sformatf("vec%0d idle", idx), 32'(busy), 32'd0);
      check($sformatf("vec%0d result_hold", idx), data_result, tbl[idx].exp_res);
   endtask

   // Reference model state: op kind (0 none, 1 mult, 2 div, 3 div-by-zero) and cycles since accept.
   int          m_op, m_e, m_ops, m_exc_cnt;
   logic [31:0] m_a, m_b, m_res;
   bit          m_exc;

   task automatic model_reset();
      m_op = 0; m_e = 0; m_ops = 0; m_exc_cnt = 0;
      m_a = '0; m_b = '0; m_res = '0; m_exc = 1'b0;
   endtask

   initial begin
      int  lat;
      bit  seen;
      tbl[0] = '{0, 1, 32'd100, 32'd7, 32'd14, 1'b0, 32'd14, 1'b0, 34};
      tbl[1] = '{0, 1, -32'sd100, 32'd0, 32'hDEAD, 1'b0, 32'd0, 1'b1, 1};
      tbl[2] = '{1, 0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 32'd0, 1'b1, 18};
      tbl[3] = '{1, 0, 32'd3, 32'd5, 32'd15, 1'b0, 32'd15, 1'b0, 18};
      tbl[4] = '{0, 1, 32'd20, 32'd4, 32'd5, 1'b0, 32'd5, 1'b0, 34};

      repeat (2) @(negedge clock);
      check_zero("reset");
      reset = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(i);

      // Abort a MULT at count 5 with a DIV; only the DIV may complete.
      @(negedge clock);
      mult_result = 32'd15; mult_ovf = 1'b0; div_result = 32'd5;
      drive_req(1'b1, 1'b0, 32'd3, 32'd5);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         drive_req(1'b0, 1'b0, 32'd0, 32'd0);
         if (mult_active && count == 6'd5) begin
            seen = 1'b1;
            break;
         end
      end
      check("abort reached_count5", 32'(seen), 32'd1);
      drive_req(1'b0, 1'b1, 32'd20, 32'd4);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if (i == 1) begin
            drive_req(1'b0, 1'b0, 32'd0, 32'd0);
            check("abort div_active", 32'(div_active), 32'd1);
            check("abort count_restart", 32'(count), 32'd0);
            check("abort op_a", op_a, 32'd20);
         end
         if (data_resultRDY) begin
            lat = i;
            break;
         end
      end
      check("abort latency", 32'(lat), 32'd34);
      check("abort result", data_result, 32'd5);

      // Simultaneous requests: MULT wins.
      @(negedge clock);
      drive_req(1'b1, 1'b1, 32'd6, 32'd7);
      @(negedge clock);
      drive_req(1'b0, 1'b0, 32'd0, 32'd0);
      check("both mult_active", 32'(mult_active), 32'd1);
      check("both div_active", 32'(div_active), 32'd0);
      repeat (20) @(negedge clock);

      // Reset in the middle of a DIV.
      div_result = 32'd14;
      drive_req(1'b0, 1'b1, 32'd100, 32'd7);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         drive_req(1'b0, 1'b0, 32'd0, 32'd0);
         if (div_active && count == 6'd10) begin
            seen = 1'b1;
            break;
         end
      end
      check("rst reached_count10", 32'(seen), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_zero("midrst");
`ifdef MULTDIV_PERF_EN
      check("midrst perf_ops", 32'(perf_ops), 32'd0);
      check("midrst perf_exc", 32'(perf_exc), 32'd0);
`endif
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (data_resultRDY || busy) seen = 1'b1;
      end
      check("midrst no_rdy", 32'(seen), 32'd0);

      run_vec(0);
      run_vec(1);
`ifdef MULTDIV_PERF_EN
      check("perf_ops", 32'(perf_ops), 32'd2);
      check("perf_exc", 32'(perf_exc), 32'd1);
`endif

      // Random phase against the cycle-since-accept model.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         int  n, r, exp_cnt;
         bit  exp_m, exp_d, exp_rdy, rq_m, rq_d, rst;
         logic [31:0] a, b, mres, dres;
         logic ovf;
         @(negedge clock);
         n       = (m_op == 1) ? MULT_N : DIV_N;
         exp_m   = (m_op == 1) && (m_e >= 1) && (m_e <= n + 1);
         exp_d   = (m_op == 2) && (m_e >= 1) && (m_e <= n + 1);
         exp_rdy = ((m_op == 3) && (m_e == 1)) || ((m_op == 1 || m_op == 2) && (m_e == n + 2));
         exp_cnt = (exp_m || exp_d) ? m_e - 1 : 0;
         check("rnd mult_active", 32'(mult_active), 32'(exp_m));
         check("rnd div_active", 32'(div_active), 32'(exp_d));
         check("rnd busy", 32'(busy), 32'(exp_m || exp_d || exp_rdy));
         check("rnd rdy", 32'(data_resultRDY), 32'(exp_rdy));
         check("rnd count", 32'(count), 32'(exp_cnt));
         check("rnd op_a", op_a, m_a);
         check("rnd op_b", op_b, m_b);
         check("rnd result", data_result, m_res);
         check("rnd exception", 32'(data_exception), 32'(m_exc));
`ifdef MULTDIV_PERF_EN
         check("rnd perf_ops", 32'(perf_ops), 32'(m_ops));
         check("rnd perf_exc", 32'(perf_exc), 32'(m_exc_cnt));
`endif
         r    = int'($urandom_range(0, 199));
         rst  = (r == 0);
         rq_m = (r >= 1 && r < 7) || (r >= 11 && r < 13);
         rq_d = (r >= 7 && r < 13);
         a    = $urandom;
         b    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         mres = $urandom;
         dres = $urandom;
         ovf  = 1'($urandom_range(0, 1));
         reset = rst;
         drive_req(rq_m, rq_d, a, b);
         mult_result = mres;
         div_result  = dres;
         mult_ovf    = ovf;
         if (rst) begin
            model_reset();
         end else begin
            if (exp_rdy) begin
               if (m_ops < 65535) m_ops++;
               if (m_exc && m_exc_cnt < 65535) m_exc_cnt++;
            end
            if (rq_m || rq_d) begin
               m_a = a; m_b = b; m_exc = 1'b0; m_e = 1;
               if (rq_m) m_op = 1;
               else if (b == 32'd0) begin
                  m_op = 3; m_res = '0; m_exc = 1'b1;
               end else m_op = 2;
            end else if (m_op != 0) begin
               if ((m_op == 1 || m_op == 2) && m_e == n + 1) begin
                  m_res = (m_op == 1) ? mres : dres;
                  m_exc = (m_op == 1) ? ovf : 1'b0;
               end
               m_e++;
               if ((m_op == 3 && m_e > 1) || m_e > n + 2) m_op = 0;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
